// File: rtl/iso14443a_tx_manchester.sv
// ISO/IEC 14443-2 Type A PICC-to-PCD transmitter at 106 kbit/s.
// Manchester-codes a bit stream into subcarrier sequences D, E and F for the load modulator.
module iso14443a_tx_manchester (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid_i,
  input  logic in_data_i,
  input  logic in_last_i,
  output logic in_ready_o,
  output logic lm_out_o,
  output logic busy_o,
  output logic underrun_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOC  = 2'd1,
    DATA = 2'd2,
    EOC  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       bit_q, bit_d;
  logic       last_q, last_d;
  logic       lm_q, lm_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;

  // D loads the first half-bit, E the second; the subcarrier is high while j mod 16 < 8.
  function automatic logic seqLoad(input logic one, input logic [6:0] j);
    return (j[3] == 1'b0) && (j[6] == ~one);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 7'd1;
    bit_d   = bit_q;
    last_d  = last_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (in_valid_i) begin
          state_d = SOC;
          bit_d   = 1'b1;
          last_d  = 1'b0;
        end
      end
      SOC, DATA: begin
        if (cnt_q == 7'd127) begin
          if (ready_q && in_valid_i) begin
            state_d = DATA;
            bit_d   = in_data_i;
            last_d  = in_last_i;
          end else begin
            state_d = EOC;
          end
        end
      end
      EOC: begin
        if (cnt_q == 7'd127) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are computed for the cycle being entered so they can be registered.
    busy_d  = (state_d != IDLE);
    lm_d    = ((state_d == SOC) || (state_d == DATA)) && seqLoad(bit_d, cnt_d);
    ready_d = (cnt_d == 7'd127) &&
              ((state_d == SOC) || ((state_d == DATA) && !last_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= 1'b0;
      last_q  <= 1'b0;
      lm_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      lm_q    <= lm_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready_o = ready_q;
  assign lm_out_o   = lm_q;
  assign busy_o     = busy_q;
  // The strobe is registered, so the pulse only follows in_valid during that one cycle.
  assign underrun_o = ready_q & ~in_valid_i;

endmodule
